// File: rtl/bsg_nasti_sram_slave_if.sv
// bsg_nasti_sram_slave_if
//
// Purpose: bundles the NASTI channels between the FSB-to-NASTI connector
// (master) and the SRAM slave memory (slave).
//
// Signals:
//   ra_*  read-address channel  (master -> slave, ready slave -> master)
//   wa_*  write-address channel (master -> slave, ready slave -> master)
//   wd_*  write-data channel    (master -> slave, ready slave -> master)
//   rd_*  read-data channel     (slave -> master, ready master -> slave)
//   wr_*  write-response channel(slave -> master, ready master -> slave)
interface bsg_nasti_sram_slave_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64,
    parameter int id_width_p   = 5,
    parameter int len_width_p  = 8
);
    logic                      ra_v;
    logic                      ra_ready;
    logic [addr_width_p-1:0]   ra_addr;
    logic [id_width_p-1:0]     ra_id;
    logic [2:0]                ra_size;
    logic [len_width_p-1:0]    ra_len;

    logic                      wa_v;
    logic                      wa_ready;
    logic [addr_width_p-1:0]   wa_addr;
    logic [id_width_p-1:0]     wa_id;
    logic [2:0]                wa_size;
    logic [len_width_p-1:0]    wa_len;

    logic                      wd_v;
    logic                      wd_ready;
    logic [data_width_p-1:0]   wd_data;
    logic [data_width_p/8-1:0] wd_strb;
    logic                      wd_last;

    logic                      rd_v;
    logic                      rd_ready;
    logic [data_width_p-1:0]   rd_data;
    logic [id_width_p-1:0]     rd_id;
    logic [1:0]                rd_resp;
    logic                      rd_last;

    logic                      wr_v;
    logic                      wr_ready;
    logic [id_width_p-1:0]     wr_id;
    logic [1:0]                wr_resp;

    modport master (
        output ra_v, ra_addr, ra_id, ra_size, ra_len,
        output wa_v, wa_addr, wa_id, wa_size, wa_len,
        output wd_v, wd_data, wd_strb, wd_last,
        output rd_ready, wr_ready,
        input  ra_ready, wa_ready, wd_ready,
        input  rd_v, rd_data, rd_id, rd_resp, rd_last,
        input  wr_v, wr_id, wr_resp
    );

    modport slave (
        input  ra_v, ra_addr, ra_id, ra_size, ra_len,
        input  wa_v, wa_addr, wa_id, wa_size, wa_len,
        input  wd_v, wd_data, wd_strb, wd_last,
        input  rd_ready, wr_ready,
        output ra_ready, wa_ready, wd_ready,
        output rd_v, rd_data, rd_id, rd_resp, rd_last,
        output wr_v, wr_id, wr_resp
    );
endinterface

// File: rtl/bsg_nasti_sram_slave.sv
// bsg_nasti_sram_slave
//
// Purpose: NASTI slave memory serving one INCR burst at a time from a
// byte-strobed word array. Stands in for the PLI memory model in FPGA and
// emulation builds.
//
// Ports:
//   clk    single clock
//   reset  synchronous active-high reset
//   bus    NASTI channels (slave modport): ra/wa/wd in, rd/wr out
module bsg_nasti_sram_slave #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64,
    parameter int id_width_p   = 5,
    parameter int len_width_p  = 8,
    parameter int els_p        = 1024
) (
    input logic                   clk,
    input logic                   reset,
    bsg_nasti_sram_slave_if.slave bus
);
    localparam int bytes_lp    = data_width_p / 8;
    localparam int lg_bytes_lp = $clog2(bytes_lp);
    localparam int lg_els_lp   = $clog2(els_p);

    localparam logic [2:0] size_ok_lp = 3'(lg_bytes_lp);

    localparam logic [1:0] resp_okay  = 2'b00;
    localparam logic [1:0] resp_slverr = 2'b10;
    localparam logic [1:0] resp_decerr = 2'b11;

    localparam logic [1:0] s_idle  = 2'd0;
    localparam logic [1:0] s_read  = 2'd1;
    localparam logic [1:0] s_write = 2'd2;
    localparam logic [1:0] s_wresp = 2'd3;

    logic [1:0]              state_r;
    logic                    pri_w_r;
    logic [lg_els_lp-1:0]    idx_r;
    logic [len_width_p-1:0]  count_r;
    logic [len_width_p-1:0]  len_r;
    logic [id_width_p-1:0]   id_r;
    logic [1:0]              resp_r;
    logic [data_width_p-1:0] rd_data_r;
    logic [data_width_p-1:0] mem [els_p];

    logic                    in_idle;
    logic                    last_beat;
    logic                    ra_fire;
    logic                    wa_fire;
    logic                    wd_fire;
    logic                    rd_fire;
    logic                    wr_fire;
    logic [lg_els_lp-1:0]    next_idx;
    logic [1:0]              ra_resp;
    logic [1:0]              wa_resp;

    // Response is decided once from the address and size: out-of-range
    // high address bits dominate a size mismatch.
    function automatic logic [1:0] resp_of(input logic [addr_width_p-1:0] addr,
                                           input logic [2:0]              size);
        if ((addr >> (lg_bytes_lp + lg_els_lp)) != '0)
            return resp_decerr;
        else if (size != size_ok_lp)
            return resp_slverr;
        else
            return resp_okay;
    endfunction

    function automatic logic [lg_els_lp-1:0] idx_of(input logic [addr_width_p-1:0] addr);
        return addr[lg_bytes_lp +: lg_els_lp];
    endfunction

    // All valids/readys are forced low while reset is held, even before the
    // state register has been cleared by the reset edge. Arbitration only
    // happens in IDLE; pri_w_r alternates the winner when both are pending.
    always_comb begin
        in_idle       = ~reset && (state_r == s_idle);
        bus.ra_ready  = in_idle && (~bus.wa_v || ~pri_w_r);
        bus.wa_ready  = in_idle && (~bus.ra_v || pri_w_r);
        bus.wd_ready  = ~reset && (state_r == s_write);
        bus.rd_v      = ~reset && (state_r == s_read);
        bus.wr_v      = ~reset && (state_r == s_wresp);
        last_beat     = (count_r == len_r);
        bus.rd_last   = bus.rd_v && last_beat;
        bus.rd_data   = reset ? '0 : rd_data_r;
        bus.rd_id     = reset ? '0 : id_r;
        bus.rd_resp   = reset ? '0 : resp_r;
        bus.wr_id     = reset ? '0 : id_r;
        bus.wr_resp   = reset ? '0 : resp_r;
        ra_fire       = bus.ra_v && bus.ra_ready;
        wa_fire       = bus.wa_v && bus.wa_ready;
        wd_fire       = bus.wd_v && bus.wd_ready;
        rd_fire       = bus.rd_v && bus.rd_ready;
        wr_fire       = bus.wr_v && bus.wr_ready;
        next_idx      = idx_r + lg_els_lp'(1);
        ra_resp       = resp_of(bus.ra_addr, bus.ra_size);
        wa_resp       = resp_of(bus.wa_addr, bus.wa_size);
    end

    // Burst control. The read data register is preloaded at acceptance so
    // the first beat is valid the next cycle, then advanced on each beat
    // handshake. A write burst ends on wd_last or the final counted beat;
    // disagreement between the two marks the burst as SLVERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= s_idle;
            pri_w_r   <= 1'b1;
            idx_r     <= '0;
            count_r   <= '0;
            len_r     <= '0;
            id_r      <= '0;
            resp_r    <= resp_okay;
            rd_data_r <= '0;
        end else begin
            case (state_r)
                s_idle: begin
                    if (wa_fire) begin
                        state_r <= s_write;
                        pri_w_r <= 1'b0;
                        idx_r   <= idx_of(bus.wa_addr);
                        count_r <= '0;
                        len_r   <= bus.wa_len;
                        id_r    <= bus.wa_id;
                        resp_r  <= wa_resp;
                    end else if (ra_fire) begin
                        state_r   <= s_read;
                        pri_w_r   <= 1'b1;
                        idx_r     <= idx_of(bus.ra_addr);
                        count_r   <= '0;
                        len_r     <= bus.ra_len;
                        id_r      <= bus.ra_id;
                        resp_r    <= ra_resp;
                        rd_data_r <= (ra_resp == resp_okay) ? mem[idx_of(bus.ra_addr)] : '0;
                    end
                end
                s_read: begin
                    if (rd_fire) begin
                        if (last_beat) begin
                            state_r <= s_idle;
                        end else begin
                            count_r   <= count_r + len_width_p'(1);
                            idx_r     <= next_idx;
                            rd_data_r <= (resp_r == resp_okay) ? mem[next_idx] : '0;
                        end
                    end
                end
                s_write: begin
                    if (wd_fire) begin
                        if (bus.wd_last || last_beat) begin
                            state_r <= s_wresp;
                            if ((bus.wd_last != last_beat) && (resp_r != resp_decerr))
                                resp_r <= resp_slverr;
                        end else begin
                            count_r <= count_r + len_width_p'(1);
                            idx_r   <= next_idx;
                        end
                    end
                end
                s_wresp: begin
                    if (wr_fire)
                        state_r <= s_idle;
                end
                default: state_r <= s_idle;
            endcase
        end
    end

    // Byte-strobed storage; contents survive reset. Error bursts never write.
    always_ff @(posedge clk) begin
        if (wd_fire && (resp_r == resp_okay)) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (bus.wd_strb[b])
                    mem[idx_r][b*8 +: 8] <= bus.wd_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_bsg_nasti_sram_slave.sv
// tb_bsg_nasti_sram_slave
//
// Purpose: self-checking bench for bsg_nasti_sram_slave. Drives directed
// and randomized bursts through the interface and compares every read beat
// and write response against a word/byte model of the memory.
module tb_bsg_nasti_sram_slave;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IW  = 5;
    localparam int LW  = 8;
    localparam int ELS = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    // Reference model: word contents plus a per-byte "written" mask so that
    // never-written (uninitialised) bytes are not compared.
    logic [63:0] refMem [ELS];
    logic [7:0]  refKnown [ELS];
    bit          modelPri = 1'b1;

    logic [63:0] wbData [16];
    logic [7:0]  wbStrb [16];

    bsg_nasti_sram_slave_if #(.addr_width_p(AW), .data_width_p(DW),
                              .id_width_p(IW), .len_width_p(LW)) bus ();

    bsg_nasti_sram_slave #(.addr_width_p(AW), .data_width_p(DW), .id_width_p(IW),
                           .len_width_p(LW), .els_p(ELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Response from the address/size rules: 8-byte beats, 1024 words, so
    // any address bit at or above bit 13 is out of range.
    function automatic logic [1:0] expResp(input logic [31:0] addr, input logic [2:0] size);
        if ((addr >> 13) != 0) return 2'b11;
        if (size != 3'd3) return 2'b10;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one address-channel request and wait (bounded) for acceptance.
    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                 input logic [4:0] id, input logic [2:0] size,
                                 input logic [7:0] len, output bit accepted);
        int cyc = 0;
        if (isWrite) begin
            bus.wa_v = 1'b1; bus.wa_addr = addr; bus.wa_id = id;
            bus.wa_size = size; bus.wa_len = len;
        end else begin
            bus.ra_v = 1'b1; bus.ra_addr = addr; bus.ra_id = id;
            bus.ra_size = size; bus.ra_len = len;
        end
        #1;
        while (!(isWrite ? bus.wa_ready : bus.ra_ready) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        accepted = isWrite ? bus.wa_ready : bus.ra_ready;
        @(posedge clk); #1;
        bus.wa_v = 1'b0;
        bus.ra_v = 1'b0;
    endtask

    // Write burst using wbData/wbStrb; wd_last is raised on beat nbeats-1.
    task automatic writeBurst(input logic [31:0] addr, input logic [4:0] id,
                              input logic [2:0] size, input logic [7:0] len,
                              input int nbeats);
        logic [1:0] resp;
        int idx, endBeat, cyc, w;
        bit acc;
        resp = expResp(addr, size);
        idx = int'((addr >> 3) % ELS);
        endBeat = (nbeats - 1 < int'(len)) ? nbeats - 1 : int'(len);
        applyStimulus(1'b1, addr, id, size, len, acc);
        checkOutput("wa_accept", 64'(acc), 64'd1);
        checkOutput("wd_ready_t1", 64'(bus.wd_ready), 64'd1);
        for (int k = 0; k <= endBeat; k++) begin
            bus.wd_v = 1'b1; bus.wd_data = wbData[k]; bus.wd_strb = wbStrb[k];
            bus.wd_last = (k == nbeats - 1);
            cyc = 0;
            #1;
            while (!bus.wd_ready && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (!bus.wd_ready) checkOutput("wd_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            if (resp == 2'b00) begin
                w = (idx + k) % ELS;
                for (int b = 0; b < 8; b++) begin
                    if (wbStrb[k][b]) begin
                        refMem[w][b*8 +: 8] = wbData[k][b*8 +: 8];
                        refKnown[w][b] = 1'b1;
                    end
                end
            end
        end
        if (nbeats - 1 > endBeat) begin
            bus.wd_v = 1'b1; bus.wd_data = wbData[endBeat+1]; bus.wd_last = 1'b0;
            #1;
            checkOutput("wd_surplus_ready", 64'(bus.wd_ready), 64'd0);
        end
        bus.wd_v = 1'b0; bus.wd_last = 1'b0;
        if ((nbeats - 1 != int'(len)) && resp != 2'b11) resp = 2'b10;
        checkOutput("wr_v_u1", 64'(bus.wr_v), 64'd1);
        checkOutput("wr_id", 64'(bus.wr_id), 64'(id));
        checkOutput("wr_resp", 64'(bus.wr_resp), 64'(resp));
        bus.wr_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("wr_v_stall", 64'(bus.wr_v), 64'd1);
        checkOutput("wr_resp_stall", 64'(bus.wr_resp), 64'(resp));
        bus.wr_ready = 1'b1;
        @(posedge clk); #1;
        bus.wr_ready = 1'b0;
        checkOutput("wr_v_done", 64'(bus.wr_v), 64'd0);
        modelPri = 1'b0;
    endtask

    // Read burst; stall toggles rd_ready 1-0-1-0 and re-checks held beats.
    task automatic readBurst(input logic [31:0] addr, input logic [4:0] id,
                             input logic [2:0] size, input logic [7:0] len,
                             input bit stall);
        logic [1:0]  resp;
        logic [63:0] expData;
        int idx, k, cyc, w;
        bit acc, phase, vSeen;
        resp = expResp(addr, size);
        idx = int'((addr >> 3) % ELS);
        applyStimulus(1'b0, addr, id, size, len, acc);
        checkOutput("ra_accept", 64'(acc), 64'd1);
        checkOutput("rd_v_t1", 64'(bus.rd_v), 64'd1);
        k = 0; cyc = 0; phase = 1'b1;
        while (k <= int'(len) && cyc < 200) begin
            bus.rd_ready = stall ? phase : 1'b1;
            phase = ~phase;
            w = (idx + k) % ELS;
            expData = (resp == 2'b00) ? refMem[w] : 64'd0;
            vSeen = bus.rd_v;
            if (vSeen) begin
                if (resp != 2'b00 || refKnown[w] == 8'hFF)
                    checkOutput("rd_data", bus.rd_data, expData);
                checkOutput("rd_id", 64'(bus.rd_id), 64'(id));
                checkOutput("rd_resp", 64'(bus.rd_resp), 64'(resp));
                checkOutput("rd_last", 64'(bus.rd_last), 64'(k == int'(len)));
            end else begin
                checkOutput("rd_v_hold", 64'(bus.rd_v), 64'd1);
            end
            @(posedge clk); #1;
            if (vSeen && bus.rd_ready) k++;
            cyc++;
        end
        bus.rd_ready = 1'b0;
        if (k <= int'(len)) checkOutput("rd_timeout", 64'd0, 64'd1);
        checkOutput("rd_v_end", 64'(bus.rd_v), 64'd0);
        modelPri = 1'b1;
    endtask

    initial begin
        int grants, cyc, word, rword, nb;
        bit acc;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len, rlen;

        for (int i = 0; i < ELS; i++) begin refMem[i] = '0; refKnown[i] = '0; end
        bus.ra_v = 0; bus.ra_addr = 0; bus.ra_id = 0; bus.ra_size = 0; bus.ra_len = 0;
        bus.wa_v = 0; bus.wa_addr = 0; bus.wa_id = 0; bus.wa_size = 0; bus.wa_len = 0;
        bus.wd_v = 0; bus.wd_data = 0; bus.wd_strb = 0; bus.wd_last = 0;
        bus.rd_ready = 0; bus.wr_ready = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ra_ready", 64'(bus.ra_ready), 64'd0);
        checkOutput("rst_wa_ready", 64'(bus.wa_ready), 64'd0);
        checkOutput("rst_wd_ready", 64'(bus.wd_ready), 64'd0);
        checkOutput("rst_rd_v", 64'(bus.rd_v), 64'd0);
        checkOutput("rst_wr_v", 64'(bus.wr_v), 64'd0);
        checkOutput("rst_rd_data", bus.rd_data, 64'd0);
        checkOutput("rst_rd_last", 64'(bus.rd_last), 64'd0);
        checkOutput("rst_wr_resp", 64'(bus.wr_resp), 64'd0);
        reset = 1'b0;
        modelPri = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_ra_ready", 64'(bus.ra_ready), 64'd1);
        checkOutput("post_rst_wa_ready", 64'(bus.wa_ready), 64'd1);

        // Basic write/read burst at 0x40.
        for (int k = 0; k < 4; k++) begin wbData[k] = 64'(k + 1) * 64'h11; wbStrb[k] = 8'hFF; end
        writeBurst(32'h40, 5'd3, 3'd3, 8'd3, 4);
        readBurst(32'h40, 5'd4, 3'd3, 8'd3, 1'b0);

        // Arbitration with both requests held: strobe-less writes, len 0.
        bus.ra_v = 1; bus.ra_addr = 32'h40; bus.ra_id = 5'd1; bus.ra_size = 3; bus.ra_len = 0;
        bus.wa_v = 1; bus.wa_addr = 32'h800; bus.wa_id = 5'd2; bus.wa_size = 3; bus.wa_len = 0;
        bus.wd_v = 1; bus.wd_strb = 0; bus.wd_last = 1; bus.wd_data = 0;
        bus.rd_ready = 1; bus.wr_ready = 1;
        grants = 0; cyc = 0;
        #1;
        while (grants < 4 && cyc < 100) begin
            if (bus.wa_ready || bus.ra_ready) begin
                checkOutput("arb_onehot", 64'(bus.wa_ready & bus.ra_ready), 64'd0);
                checkOutput("arb_grant_is_w", 64'(bus.wa_ready), 64'(modelPri));
                modelPri = bus.ra_ready && !bus.wa_ready;
                grants++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("arb_grants", 64'(grants), 64'd4);
        bus.ra_v = 0; bus.wa_v = 0; bus.wd_v = 0; bus.wd_last = 0;
        repeat (3) begin @(posedge clk); #1; end
        bus.rd_ready = 0; bus.wr_ready = 0;

        // Partial strobes.
        wbData[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbStrb[0] = 8'hFF;
        writeBurst(32'h100, 5'd5, 3'd3, 8'd0, 1);
        wbData[0] = 64'h0; wbStrb[0] = 8'h0F;
        writeBurst(32'h100, 5'd6, 3'd3, 8'd0, 1);
        readBurst(32'h100, 5'd7, 3'd3, 8'd0, 1'b0);

        // Stalled len-7 read.
        for (int k = 0; k < 8; k++) begin wbData[k] = {$urandom, $urandom}; wbStrb[k] = 8'hFF; end
        writeBurst(32'h200, 5'd8, 3'd3, 8'd7, 8);
        readBurst(32'h200, 5'd9, 3'd3, 8'd7, 1'b1);

        // Wrap-around at the top of memory.
        for (int k = 0; k < 4; k++) begin wbData[k] = {$urandom, $urandom}; wbStrb[k] = 8'hFF; end
        writeBurst(32'((ELS - 2) * 8), 5'd10, 3'd3, 8'd3, 4);
        readBurst(32'((ELS - 2) * 8), 5'd11, 3'd3, 8'd3, 1'b0);

        // Size error: zero data on reads, no memory change on writes.
        readBurst(32'h40, 5'd12, 3'd2, 8'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin wbData[k] = 64'hDEAD_BEEF_0000_0000 + 64'(k); wbStrb[k] = 8'hFF; end
        writeBurst(32'h40, 5'd13, 3'd2, 8'd3, 4);
        readBurst(32'h40, 5'd14, 3'd3, 8'd3, 1'b0);

        // Decode error: address aliases word 0 if decoded wrongly.
        writeBurst(32'h8000_0000, 5'd15, 3'd3, 8'd1, 2);
        readBurst(32'h8000_0000, 5'd16, 3'd3, 8'd1, 1'b0);
        readBurst(32'h0, 5'd17, 3'd3, 8'd1, 1'b0);

        // Early wd_last, then a late wd_last with a surplus beat.
        for (int k = 0; k < 8; k++) begin wbData[k] = {$urandom, $urandom}; wbStrb[k] = 8'hFF; end
        writeBurst(32'h300, 5'd18, 3'd3, 8'd3, 2);
        readBurst(32'h300, 5'd19, 3'd3, 8'd1, 1'b0);
        writeBurst(32'h380, 5'd20, 3'd3, 8'd1, 4);
        readBurst(32'h380, 5'd21, 3'd3, 8'd1, 1'b0);

        // Randomized traffic over a small window.
        for (int it = 0; it < 12; it++) begin
            word = $urandom_range(0, 63);
            len = 8'($urandom_range(0, 7));
            addr = 32'(word * 8);
            if ($urandom_range(0, 5) == 0) addr = addr | 32'h0010_0000;
            size = ($urandom_range(0, 4) == 0) ? 3'd2 : 3'd3;
            nb = int'(len) + 1;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 9);
            for (int k = 0; k < 16; k++) begin
                wbData[k] = {$urandom, $urandom};
                wbStrb[k] = 8'($urandom_range(0, 255));
            end
            writeBurst(addr, 5'(it), size, len, nb);
            rword = $urandom_range(0, 63);
            rlen = 8'($urandom_range(0, 7));
            readBurst(32'(rword * 8), 5'(it + 1), 3'd3, rlen, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a stalled read.
        bus.rd_ready = 0;
        applyStimulus(1'b0, 32'h200, 5'd9, 3'd3, 8'd7, acc);
        checkOutput("mid_ra_accept", 64'(acc), 64'd1);
        @(posedge clk); #1;
        checkOutput("mid_rd_v", 64'(bus.rd_v), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_rst_rd_v", 64'(bus.rd_v), 64'd0);
        checkOutput("mid_rst_wr_v", 64'(bus.wr_v), 64'd0);
        checkOutput("mid_rst_ra_ready", 64'(bus.ra_ready), 64'd0);
        checkOutput("mid_rst_wd_ready", 64'(bus.wd_ready), 64'd0);
        checkOutput("mid_rst_rd_data", bus.rd_data, 64'd0);
        reset = 1'b0;
        modelPri = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_post_ra_ready", 64'(bus.ra_ready), 64'd1);
        checkOutput("mid_post_rd_v", 64'(bus.rd_v), 64'd0);
        readBurst(32'h200, 5'd22, 3'd3, 8'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
